// File: rtl/spi_core_pkg.sv
// spi_core_pkg: shared types and constants for the SPI master slice.
//   spi_state_t    : controller state (IDLE, SHIFT)
//   DEF_DWIDTH     : default word length in bits
//   DEF_CLK_DIV    : default sclk half-period in clk cycles
//   cnt_width()    : width of a counter that must hold 0..dwidth
package spi_core_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

   localparam int DEF_DWIDTH  = 8;
   localparam int DEF_CLK_DIV = 1;

   function automatic int cnt_width(input int dwidth);
      return $clog2(dwidth + 1);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: CLK_DIV prescaler for the SPI clock.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   en   : high while a transfer is in progress; low forces sclk low
//   sclk : registered SPI clock, idles low
//   rise : single-cycle pulse, high in the cycle whose rising clk edge
//          takes sclk from 0 to 1
//   fall : single-cycle pulse, high in the cycle whose rising clk edge
//          takes sclk from 1 to 0
module spi_clk_gen
   import spi_core_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_cnt;
   logic          tick;

   // The pulses announce the edge about to happen, so the core acts on the
   // same clk edge that moves sclk.
   assign tick = en && (div_cnt == DW'(CLK_DIV - 1));
   assign rise = tick & ~sclk;
   assign fall = tick & sclk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

endmodule

// File: rtl/spi_core.sv
// spi_core: single-channel SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   cs    : host bus select, qualifies rd/wr
//   rd    : host read strobe (no side effects, dout always readable)
//   wr    : host write strobe, starts a transfer
//   din   : word to transmit
//   dout  : last received word
//   miso  : serial data from the secondary
//   mosi  : serial data to the secondary
//   sclk  : SPI clock, idles low
//   done  : high when idle / previous transfer complete
//   state : current controller state, for observation only
// Optional build macro SPI_CORE_ASSERT_EN compiles in property checks.
//
// Host handshake: a write is accepted on a rising clk edge where
// cs & wr & ~rd & done are all high ("valid" = cs & wr & ~rd, "ready" =
// done). Strobes seen while done is low are dropped, not queued.
module spi_core
   import spi_core_pkg::*;
#(
   parameter int DWIDTH  = DEF_DWIDTH,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              rd,
   input  logic              wr,
   input  logic [DWIDTH-1:0] din,
   output logic [DWIDTH-1:0] dout,
   input  logic              miso,
   output logic              mosi,
   output logic              sclk,
   output logic              done,
   output spi_state_t        state
);

   localparam int CW = cnt_width(DWIDTH);

   logic [DWIDTH-1:0] tx_sr;   // bits still to send, next one at the MSB
   logic [DWIDTH-1:0] rx_sr;
   logic [CW-1:0]     bit_cnt; // rising sclk edges seen this transfer
   logic              start;
   logic              shift_en;
   logic              sclk_rise;
   logic              sclk_fall;

   assign start    = cs & wr & ~rd & done;
   assign shift_en = (state == SHIFT);

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (shift_en),
      .sclk (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         tx_sr   <= '0;
         rx_sr   <= '0;
         bit_cnt <= '0;
         mosi    <= 1'b0;
         dout    <= '0;
         done    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // MSB goes straight onto mosi; the register keeps the rest.
                  tx_sr   <= {din[DWIDTH-2:0], 1'b0};
                  mosi    <= din[DWIDTH-1];
                  rx_sr   <= '0;
                  bit_cnt <= '0;
                  done    <= 1'b0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  rx_sr   <= {rx_sr[DWIDTH-2:0], miso};
                  bit_cnt <= bit_cnt + CW'(1);
               end
               if (sclk_fall) begin
                  if (bit_cnt == CW'(DWIDTH)) begin
                     // Final falling edge: commit the word and go idle.
                     dout  <= rx_sr;
                     done  <= 1'b1;
                     mosi  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     mosi  <= tx_sr[DWIDTH-1];
                     tx_sr <= {tx_sr[DWIDTH-2:0], 1'b0};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_CORE_ASSERT_EN
   a_sclk_low_when_done: assert property (
      @(posedge clk) disable iff (!rst) done |-> !sclk);
   a_done_falls_on_start: assert property (
      @(posedge clk) disable iff (!rst) $fell(done) |-> $past(start));
   a_bit_cnt_range: assert property (
      @(posedge clk) disable iff (!rst) bit_cnt <= CW'(DWIDTH));
   a_dout_on_done_rise: assert property (
      @(posedge clk) disable iff (!rst) $changed(dout) |-> $rose(done));
`else
`endif

endmodule

// File: tb/tb_spi_core.sv
module tb_spi_core;
   import spi_core_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT (defaults: DWIDTH=8, CLK_DIV=1) ----------------
   logic       cs = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       miso, mosi, sclk, done;
   spi_state_t state;

   spi_core u_dut (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs),
      .rd    (rd),
      .wr    (wr),
      .din   (din),
      .dout  (dout),
      .miso  (miso),
      .mosi  (mosi),
      .sclk  (sclk),
      .done  (done),
      .state (state)
   );

   // ---------------- DUT with CLK_DIV=3, miso tied high ----------------
   logic       cs3 = 1'b0, rd3 = 1'b0, wr3 = 1'b0;
   logic [7:0] din3 = 8'h00;
   logic [7:0] dout3;
   logic       miso3 = 1'b1;
   logic       mosi3, sclk3, done3;
   spi_state_t state3;

   spi_core #(.DWIDTH(8), .CLK_DIV(3)) u_dut3 (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs3),
      .rd    (rd3),
      .wr    (wr3),
      .din   (din3),
      .dout  (dout3),
      .miso  (miso3),
      .mosi  (mosi3),
      .sclk  (sclk3),
      .done  (done3),
      .state (state3)
   );

   // ---------------- mode-0 secondary model ----------------
   logic [7:0] sec_reg = 8'h00;
   logic [7:0] sec_ld_val = 8'h00;
   logic       sec_ld = 1'b0;
   logic       sec_samp = 1'b0;

   assign miso = sec_reg[7];

   always @(posedge sclk) sec_samp = mosi;

   always @(negedge sclk or posedge sec_ld) begin
      if (sec_ld) sec_reg = sec_ld_val;
      else        sec_reg = {sec_reg[6:0], sec_samp};
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp_v;
      exp_v = exp_q.pop_front();
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- driver ----------------
   // Call at a negedge; returns at the negedge where done is seen high again.
   task automatic run_xfer(input logic [7:0] tx, input logic load_sec,
                           input logic [7:0] sec_val, input int pulse_at,
                           output int rises, output logic [7:0] bits,
                           output int done_cyc);
      int   cyc;
      logic prev;
      if (load_sec) begin
         sec_ld_val = sec_val;
         sec_ld = 1'b1;
         #1 sec_ld = 1'b0;
      end
      cs = 1'b1; rd = 1'b0; wr = 1'b1; din = tx;
      @(negedge clk);
      wr = 1'b0;
      exp_q.push_back(0); check("busy_after_accept", done);
      exp_q.push_back({31'd0, tx[7]}); check("mosi_first_bit", mosi);
      rises = 0; bits = 8'h00; cyc = 0; prev = sclk;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         wr  = (cyc == pulse_at);
         din = (cyc == pulse_at) ? ~tx : tx;
         if (sclk && !prev) begin
            rises++;
            bits = {bits[6:0], mosi};
         end
         prev = sclk;
      end
      wr = 1'b0;
      done_cyc = done ? cyc : -1;
   endtask

   // ---------------- directed sequence ----------------
   int         rises, done_cyc, hi_cnt, toggles, first_tog, last_tog, bad_half, cyc;
   logic [7:0] bits;
   logic       prev;

   initial begin
      // Reset then idle
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      hi_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (sclk) hi_cnt++;
      end
      exp_q.push_back(1); check("rst_done", done);
      exp_q.push_back(0); check("rst_sclk", sclk);
      exp_q.push_back(0); check("rst_mosi", mosi);
      exp_q.push_back(0); check("rst_dout", dout);
      exp_q.push_back(IDLE); check("rst_state", state);
      exp_q.push_back(0); check("idle_sclk_quiet", hi_cnt);

      // Loopback 0xAA against secondary holding 0x3C
      run_xfer(8'hAA, 1'b1, 8'h3C, 0, rises, bits, done_cyc);
      exp_q.push_back(8);     check("lb_sclk_pulses", rises);
      exp_q.push_back(8'hAA); check("lb_mosi_bits", bits);
      exp_q.push_back(16);    check("lb_latency", done_cyc);
      exp_q.push_back(8'h3C); check("lb_dout", dout);
      exp_q.push_back(8'hAA); check("lb_sec", sec_reg);
      exp_q.push_back(0);     check("lb_sclk_idle", sclk);
      exp_q.push_back(0);     check("lb_mosi_idle", mosi);

      // Back-to-back: 0xFF then 0x00 on the cycle done rises
      run_xfer(8'hFF, 1'b1, 8'h11, 0, rises, bits, done_cyc);
      exp_q.push_back(16);    check("b2b1_latency", done_cyc);
      exp_q.push_back(8'h11); check("b2b1_dout", dout);
      run_xfer(8'h00, 1'b0, 8'h00, 0, rises, bits, done_cyc);
      exp_q.push_back(16);    check("b2b2_latency", done_cyc);
      exp_q.push_back(8'hFF); check("b2b2_dout", dout);
      exp_q.push_back(8'h00); check("b2b2_sec", sec_reg);

      // wr pulsed mid-transfer is ignored
      run_xfer(8'h3C, 1'b1, 8'h96, 5, rises, bits, done_cyc);
      exp_q.push_back(16);    check("midwr_latency", done_cyc);
      exp_q.push_back(8'h3C); check("midwr_mosi_bits", bits);
      exp_q.push_back(8'h96); check("midwr_dout", dout);
      exp_q.push_back(8'h3C); check("midwr_sec", sec_reg);
      @(negedge clk);
      exp_q.push_back(1); check("midwr_no_restart", done);

      // rd & wr together while idle
      cs = 1'b1; rd = 1'b1; wr = 1'b1; din = 8'h55;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.push_back(1);     check("rdwr_done", done);
      exp_q.push_back(0);     check("rdwr_sclk", sclk);
      exp_q.push_back(8'h96); check("rdwr_dout", dout);

      // wr with cs=0
      cs = 1'b0; wr = 1'b1; din = 8'h55;
      @(negedge clk);
      wr = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.push_back(1);     check("nocs_done", done);
      exp_q.push_back(IDLE);  check("nocs_state", state);
      exp_q.push_back(8'h96); check("nocs_dout", dout);

      // Reset mid-transfer after 3 bits
      sec_ld_val = 8'hF0; sec_ld = 1'b1; #1 sec_ld = 1'b0;
      cs = 1'b1; wr = 1'b1; din = 8'hE7;
      @(negedge clk);
      wr = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      exp_q.push_back(1);    check("midrst_done", done);
      exp_q.push_back(0);    check("midrst_sclk", sclk);
      exp_q.push_back(0);    check("midrst_mosi", mosi);
      exp_q.push_back(0);    check("midrst_dout", dout);
      exp_q.push_back(IDLE); check("midrst_state", state);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_xfer(8'h5A, 1'b1, 8'hC3, 0, rises, bits, done_cyc);
      exp_q.push_back(16);    check("postrst_latency", done_cyc);
      exp_q.push_back(8'h5A); check("postrst_mosi_bits", bits);
      exp_q.push_back(8'hC3); check("postrst_dout", dout);
      exp_q.push_back(8'h5A); check("postrst_sec", sec_reg);

      // CLK_DIV=3 instance, miso held high
      cs3 = 1'b1; wr3 = 1'b1; din3 = 8'h81;
      @(negedge clk);
      wr3 = 1'b0;
      exp_q.push_back(0); check("div3_busy", done3);
      cyc = 0; prev = sclk3; toggles = 0; first_tog = -1; last_tog = 0; bad_half = 0;
      while (!done3 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (sclk3 != prev) begin
            toggles++;
            if (first_tog < 0) first_tog = cyc;
            else if (cyc - last_tog != 3) bad_half++;
            last_tog = cyc;
         end
         prev = sclk3;
      end
      exp_q.push_back(3);     check("div3_first_rise", first_tog);
      exp_q.push_back(0);     check("div3_half_period", bad_half);
      exp_q.push_back(16);    check("div3_toggles", toggles);
      exp_q.push_back(48);    check("div3_latency", done3 ? cyc : -1);
      exp_q.push_back(8'hFF); check("div3_dout", dout3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
